// File: rtl/change_dispenser.sv
// Coin payout engine: pays a cent amount greedily from five coin tubes, one solenoid pulse at a time,
// tracking tube inventory and reporting any unpaid remainder or ejector jam.
module change_dispenser #(
  parameter int AMT_W      = 9,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 20,
  parameter int TIMEOUT    = 255,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic             eject_ack,
  output logic [4:0]       eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] short,
  output logic [AMT_W-1:0] paid,
  output logic [4:0]       empty
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

  function automatic logic [AMT_W-1:0] coinValue(input logic [2:0] idx);
    case (idx)
      3'd4:    coinValue = AMT_W'(100);
      3'd3:    coinValue = AMT_W'(50);
      3'd2:    coinValue = AMT_W'(25);
      3'd1:    coinValue = AMT_W'(10);
      default: coinValue = AMT_W'(5);
    endcase
  endfunction

  state_t             state, stateNext;
  logic [AMT_W-1:0]   rem, remNext;
  logic [2:0]         selIdx, selIdxNext;
  logic [TMR_W-1:0]   tmr, tmrNext;
  logic [GAP_W-1:0]   gapCnt, gapCntNext;
  logic [CNT_W-1:0]   cnt [5];
  logic [CNT_W-1:0]   cntNext [5];
  logic [4:0]         ejectNext, emptyNext;
  logic               busyNext, doneNext, faultNext;
  logic [AMT_W-1:0]   shortNext, paidNext;
  logic               found;
  logic [2:0]         pickIdx;

  always_comb begin
    stateNext  = state;
    remNext    = rem;
    selIdxNext = selIdx;
    tmrNext    = tmr;
    gapCntNext = gapCnt;
    cntNext    = cnt;
    ejectNext  = eject;
    busyNext   = busy;
    doneNext   = 1'b0;
    faultNext  = fault;
    shortNext  = short;
    paidNext   = paid;
    found      = 1'b0;
    pickIdx    = 3'd0;

    // Largest denomination that fits the remainder and is still stocked.
    for (int i = 4; i >= 0; i--) begin
      if (!found && coinValue(3'(i)) <= rem && cnt[i] != '0) begin
        found   = 1'b1;
        pickIdx = 3'(i);
      end
    end

    case (state)
      IDLE: begin
        if (refill) begin
          for (int i = 0; i < 5; i++) cntNext[i] = CNT_W'(INIT_COUNT);
        end
        if (start) begin
          remNext   = amount;
          paidNext  = '0;
          shortNext = '0;
          faultNext = 1'b0;
          busyNext  = 1'b1;
          stateNext = SELECT;
        end
      end
      SELECT: begin
        if (!found) begin
          doneNext  = 1'b1;
          shortNext = rem;
          stateNext = FINISH;
        end else begin
          ejectNext  = 5'b00001 << pickIdx;
          selIdxNext = pickIdx;
          tmrNext    = '0;
          stateNext  = EJECT;
        end
      end
      EJECT: begin
        if (eject_ack) begin
          ejectNext  = '0;
          if (cnt[selIdx] != '0) cntNext[selIdx] = cnt[selIdx] - CNT_W'(1);
          remNext    = rem - coinValue(selIdx);
          paidNext   = paid + coinValue(selIdx);
          gapCntNext = '0;
          stateNext  = GAP;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          // Jammed: the coin never left, so inventory and remainder stay as they were.
          ejectNext = '0;
          faultNext = 1'b1;
          doneNext  = 1'b1;
          shortNext = rem;
          stateNext = FINISH;
        end else begin
          tmrNext = tmr + TMR_W'(1);
        end
      end
      GAP: begin
        if (gapCnt == GAP_W'(GAP_CYCLES - 1)) stateNext = SELECT;
        else gapCntNext = gapCnt + GAP_W'(1);
      end
      FINISH: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    for (int i = 0; i < 5; i++) emptyNext[i] = (cntNext[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tmr    <= '0;
      gapCnt <= '0;
      eject  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fault  <= 1'b0;
      short  <= '0;
      paid   <= '0;
      empty  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= CNT_W'(INIT_COUNT);
    end else begin
      state  <= stateNext;
      tmr    <= tmrNext;
      gapCnt <= gapCntNext;
      eject  <= ejectNext;
      busy   <= busyNext;
      done   <= doneNext;
      fault  <= faultNext;
      short  <= shortNext;
      paid   <= paidNext;
      empty  <= emptyNext;
      for (int i = 0; i < 5; i++) cnt[i] <= cntNext[i];
    end
  end

  // Working remainder and coin selection are only meaningful after a start loads them.
  always_ff @(posedge clk) begin
    rem    <= remNext;
    selIdx <= selIdxNext;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy-payout inventory model.
module tb_change_dispenser;
  localparam int AMT_W      = 9;
  localparam int CNT_W      = 8;
  localparam int INIT_COUNT = 3;
  localparam int TIMEOUT    = 20;
  localparam int GAP_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset, start, refill, eject_ack;
  logic [AMT_W-1:0] amount;
  logic [4:0]       eject, empty;
  logic             busy, done, fault;
  logic [AMT_W-1:0] short, paid;

  always #5 clk = ~clk;

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT),
    .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .refill(refill),
    .eject_ack(eject_ack), .eject(eject), .busy(busy), .done(done), .fault(fault),
    .short(short), .paid(paid), .empty(empty)
  );

  int nVec = 0;
  int nErr = 0;
  int mCnt[5];
  int coinVal[5] = '{5, 10, 25, 50, 100};

  task automatic checkVal(input string tag, input int obs, input int exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int emptyModel();
    int e = 0;
    for (int i = 0; i < 5; i++) if (mCnt[i] == 0) e |= (1 << i);
    return e;
  endfunction

  task automatic refillModel();
    for (int i = 0; i < 5; i++) mCnt[i] = INIT_COUNT;
  endtask

  // jamAt: index in the coin sequence that is never acknowledged (-1 = none)
  task automatic payout(input int amt, input int jamAt, input bit noise,
                        input bit withRefill, input bit resetMid);
    int q[$];
    int mrem, mpaid, k, idx, expFault, coinNo, lowCnt, hi, paidSoFar, cycles, expEj;
    bit gotDone;
    if (withRefill) refillModel();
    mrem = amt; mpaid = 0; expFault = 0; k = 0;
    while (1) begin
      idx = -1;
      for (int i = 4; i >= 0; i--)
        if (idx < 0 && coinVal[i] <= mrem && mCnt[i] > 0) idx = i;
      if (idx < 0) break;
      q.push_back(idx);
      if (k == jamAt) begin expFault = 1; break; end
      mCnt[idx]--; mrem -= coinVal[idx]; mpaid += coinVal[idx]; k++;
    end

    @(negedge clk);
    start = 1'b1; amount = AMT_W'(amt); refill = withRefill;
    @(negedge clk);
    start = 1'b0; refill = 1'b0; amount = AMT_W'($urandom);
    checkVal("busyAfterStart", busy, 1);
    checkVal("paidCleared", paid, 0);

    coinNo = 0; cycles = 0; gotDone = 0; paidSoFar = 0; lowCnt = 0;
    while (!gotDone && cycles < 1000) begin
      if (done) gotDone = 1;
      else if (eject != 0) begin
        expEj = (coinNo < q.size()) ? (1 << q[coinNo]) : 0;
        checkVal("ejectCoin", eject, expEj);
        checkVal("ejectLatency", lowCnt, (coinNo == 0) ? 1 : GAP_CYCLES + 1);
        if (resetMid) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          checkVal("resetEject", eject, 0);
          checkVal("resetBusy", busy, 0);
          checkVal("resetPaid", paid, 0);
          refillModel();
          repeat (4) begin
            @(negedge clk);
            checkVal("noDoneAfterReset", done, 0);
          end
          checkVal("resetEmpty", empty, 0);
          return;
        end
        if (coinNo == jamAt) begin
          hi = 0;
          while (eject != 0 && hi < TIMEOUT + 5) begin
            hi++; @(negedge clk); cycles++;
          end
          checkVal("jamLength", hi, TIMEOUT);
          lowCnt = 0;
        end else begin
          if (noise && coinNo == 0) begin
            start = 1'b1; refill = 1'b1; amount = AMT_W'($urandom_range(5, 500));
            @(negedge clk);
            start = 1'b0; refill = 1'b0; cycles++;
            checkVal("ejectHeldNoise", eject, expEj);
          end
          repeat ($urandom_range(0, 2)) begin @(negedge clk); cycles++; end
          eject_ack = 1'b1;
          @(negedge clk);
          eject_ack = 1'b0; cycles++;
          if (coinNo < q.size()) paidSoFar += coinVal[q[coinNo]];
          checkVal("ejectDropOnAck", eject, 0);
          checkVal("paidRunning", paid, paidSoFar);
          lowCnt = 0;
          coinNo++;
        end
      end else begin
        lowCnt++; @(negedge clk); cycles++;
      end
    end
    if (!gotDone) checkVal("doneTimeout", 0, 1);
    checkVal("coinsAcked", coinNo, expFault ? q.size() - 1 : q.size());
    checkVal("fault", fault, expFault);
    checkVal("short", short, mrem);
    checkVal("paidFinal", paid, mpaid);
    checkVal("empty", empty, emptyModel());
    checkVal("busyAtDone", busy, 1);
    @(negedge clk);
    checkVal("donePulse", done, 0);
    checkVal("busyCleared", busy, 0);
    checkVal("shortHeld", short, mrem);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int amt, jam, sz;
    reset = 1'b1; start = 1'b0; refill = 1'b0; eject_ack = 1'b0; amount = '0;
    refillModel();
    repeat (3) @(negedge clk);
    checkVal("rstEject", eject, 0);
    checkVal("rstBusy", busy, 0);
    checkVal("rstDone", done, 0);
    checkVal("rstFault", fault, 0);
    checkVal("rstShort", short, 0);
    checkVal("rstPaid", paid, 0);
    checkVal("rstEmpty", empty, 0);
    reset = 1'b0;
    @(negedge clk);

    payout(90, -1, 0, 0, 0);
    payout(7, -1, 0, 0, 0);
    payout(25, 0, 0, 0, 0);
    payout(90, -1, 1, 0, 0);
    payout(100, -1, 0, 0, 1);
    payout(0, -1, 0, 0, 0);
    payout(500, -1, 0, 0, 0);
    payout(500, -1, 0, 0, 0);
    payout(15, -1, 0, 0, 0);

    // Stray ack while idle, then idle refill.
    @(negedge clk); eject_ack = 1'b1; refill = 1'b1;
    @(negedge clk); eject_ack = 1'b0; refill = 1'b0;
    refillModel();
    checkVal("refillEmpty", empty, 0);
    checkVal("idleEject", eject, 0);
    checkVal("idleBusy", busy, 0);
    payout(60, -1, 0, 0, 0);
    payout(115, -1, 0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      amt = ($urandom_range(0, 3) == 0) ? 5 * $urandom_range(0, 100) : $urandom_range(0, 500);
      jam = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      payout(amt, jam, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), 1'b0);
      sz = $urandom_range(0, 2);
      repeat (sz) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
